gray_frame_sequencer: RTL
=========================

// Module: gray_frame_sequencer
// PURPOSE
//   Front-end controller for the RGB->gray datapath. It admits source pixels one frame at a
//   time, counts columns and rows, and generates the datapath sof. It also runs credit-based
//   flow control: the datapath front pipeline cannot stall, so pixels in flight never exceed
//   the end-buffer depth. Sits between the pixel source and datapath_gray (data_in/valid_in/sof_in).
// PARAMETERS
//   P_COLS     8   pixels per row (matches datapath C_ROW_SIZE)
//   P_ROWS     4   rows per frame
//   P_CREDITS  18  max pixels in flight between admission and accepted output (end-buffer depth)
// PORTS
//   i_clk          in   1   clock
//   i_rst          in   1   reset, synchronous, active-high
//   i_start        in   1   start one frame; honoured only in IDLE
//   i_src_data     in   24  source pixel {B,G,R}, 8b each, R in [7:0]
//   i_src_valid    in   1   source pixel valid
//   o_src_ready    out  1   source handshake ready (combinational)
//   o_dp_data      out  24  pixel to datapath data_in (registered)
//   o_dp_valid     out  1   to datapath valid_in (registered)
//   o_dp_sof       out  1   to datapath sof_in (registered, first pixel of frame)
//   i_dp_valid_out in   1   datapath valid_out (observed)
//   i_sink_busy    in   1   sink backpressure, same net as datapath busy_in
//   o_inflight     out  $clog2(P_CREDITS+1)  current in-flight count
//   o_frame_done   out  1   one-cycle pulse when frame fully drained
//   o_active       out  1   high in RUN or DRAIN
//   o_err          out  1   sticky: credit return with o_inflight==0
// BEHAVIOUR
//   Reset: state=IDLE; all outputs 0; col/row counters 0. Reset mid-frame abandons the frame.
//     The datapath must be reset in the same cycle.
//   FSM: IDLE -(i_start)-> RUN -(last pixel admitted)-> DRAIN -(o_inflight==0)-> DONE -> IDLE.
//     DONE lasts 1 cycle, o_frame_done=1. i_start outside IDLE is ignored.
//   credit_ok = (o_inflight < P_CREDITS). Same-cycle returns do NOT count toward credit_ok.
//   o_src_ready = (state==RUN) & credit_ok. admit = o_src_ready & i_src_valid.
//   Admit cycle N -> cycle N+1: o_dp_valid=1, o_dp_data=pixel, o_dp_sof=(col==0&&row==0).
//     With no admit, o_dp_valid=0 and o_dp_data holds its value.
//   Counters: col increments on admit and wraps at P_COLS-1 -> 0, which increments row.
//     The admit at col==P_COLS-1 && row==P_ROWS-1 is the last pixel: counters -> 0, state -> DRAIN.
//   ret = i_dp_valid_out & ~i_sink_busy. o_inflight += admit, -= ret.
//     admit & ret in the same cycle: count unchanged.
//   ret with o_inflight==0: count stays 0, o_err<=1 (sticky until reset).
//   o_inflight never exceeds P_CREDITS (assertion).
//   o_active = state in {RUN, DRAIN}.
// STRUCTURE
//   Shared package gray_pkg:
//     PIX_W=8, RGB_W=24, GRAY_DP_LATENCY=10, GRAY_BUF_DEPTH=18,
//     state typedef {IDLE,RUN,DRAIN,DONE}.
//   Sub-module credit_counter (P_MAX): inc/dec/count/at_max/underflow. Reused by other datapaths.
//   Top: FSM, col/row counters, output register stage.
// TESTING
//   1 Reset, i_start, source always valid, sink never busy, datapath model attached (latency 10).
//     -> 32 admits; o_dp_sof only on 1st pixel; o_frame_done one pulse after the last output
//        is returned; back to IDLE.
//   2 i_sink_busy held 1 from start.
//     -> exactly 18 admits, then o_src_ready=0 and o_inflight=18.
//        Release busy -> ready reasserts the cycle after the first return.
//   3 Admit and return in the same cycle at o_inflight=5 -> o_inflight stays 5.
//        Inject ret at o_inflight=0 -> o_err=1, count 0.
//   4 Source valid toggled 1010..., P_COLS=8.
//     -> col wraps 7->0 and row advances on the 8th admit; data order preserved at o_dp_data.
//   5 i_rst asserted during RUN at pixel 13 -> next cycle all outputs 0, state IDLE.
//        New i_start -> sof on first pixel again.
//   6 i_start pulsed during DRAIN -> ignored; exactly one o_frame_done; no second frame begins.

Source files
------------

// File: rtl/gray_pkg.sv
`default_nettype none
// ============================================================================
// Module      : gray_pkg
// Description : Shared constants and types for the RGB->gray front end.
// Revision    : 1.0 - initial release
// ============================================================================
package gray_pkg;

    localparam int PIX_W           = 8;
    localparam int RGB_W           = 3 * PIX_W;
    localparam int GRAY_DP_LATENCY = 10;
    localparam int GRAY_BUF_DEPTH  = 18;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        RUN   = 2'd1,
        DRAIN = 2'd2,
        DONE  = 2'd3
    } state_t;

endpackage
`default_nettype wire

// File: rtl/credit_counter.sv
`default_nettype none
// ============================================================================
// Module      : credit_counter
// Description : Up/down in-flight counter bounded to [0, P_MAX]. A return
//               seen while empty leaves the count at zero and raises
//               o_underflow for that cycle.
// Revision    : 1.0 - initial release
// ============================================================================
module credit_counter #(
    parameter int P_MAX = 18,
    parameter int CNT_W = $clog2(P_MAX + 1)
) (
    input  logic             i_clk,
    input  logic             i_rst,
    input  logic             i_inc,
    input  logic             i_dec,
    output logic [CNT_W-1:0] o_count,
    output logic             o_at_max,
    output logic             o_underflow
);

    logic [CNT_W-1:0] count_q;
    logic [CNT_W-1:0] count_d;

    assign o_count     = count_q;
    assign o_at_max    = (count_q == CNT_W'(P_MAX));
    assign o_underflow = i_dec && (count_q == '0);

    // Simultaneous inc and dec cancel; saturate at both ends.
    always_comb begin
        count_d = count_q;
        if (i_inc && !i_dec && !o_at_max) begin
            count_d = count_q + CNT_W'(1);
        end else if (!i_inc && i_dec && (count_q != '0)) begin
            count_d = count_q - CNT_W'(1);
        end
    end

    // Count register.
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            count_q <= '0;
        end else begin
            count_q <= count_d;
        end
    end

    a_never_over_max: assert property (@(posedge i_clk) disable iff (i_rst) count_q <= CNT_W'(P_MAX));

endmodule
`default_nettype wire

// File: rtl/gray_frame_sequencer.sv
`default_nettype none
// ============================================================================
// Module      : gray_frame_sequencer
// Description : Admits one frame of source pixels into the gray datapath,
//               tracks col/row, generates sof and throttles admission so that
//               pixels in flight never exceed the datapath end-buffer depth.
// Revision    : 1.0 - initial release
// ============================================================================
module gray_frame_sequencer
    import gray_pkg::*;
#(
    parameter int P_COLS    = 8,
    parameter int P_ROWS    = 4,
    parameter int P_CREDITS = GRAY_BUF_DEPTH
) (
    input  logic                           i_clk,
    input  logic                           i_rst,
    input  logic                           i_start,
    input  logic [RGB_W-1:0]               i_src_data,
    input  logic                           i_src_valid,
    output logic                           o_src_ready,
    output logic [RGB_W-1:0]               o_dp_data,
    output logic                           o_dp_valid,
    output logic                           o_dp_sof,
    input  logic                           i_dp_valid_out,
    input  logic                           i_sink_busy,
    output logic [$clog2(P_CREDITS+1)-1:0] o_inflight,
    output logic                           o_frame_done,
    output logic                           o_active,
    output logic                           o_err
);

    localparam int COL_W = (P_COLS > 1) ? $clog2(P_COLS) : 1;
    localparam int ROW_W = (P_ROWS > 1) ? $clog2(P_ROWS) : 1;
    localparam int INF_W = $clog2(P_CREDITS + 1);

    state_t             state_q;
    state_t             state_d;
    logic [COL_W-1:0]   col_q;
    logic [COL_W-1:0]   col_d;
    logic [ROW_W-1:0]   row_q;
    logic [ROW_W-1:0]   row_d;
    logic [RGB_W-1:0]   dp_data_q;
    logic               dp_valid_q;
    logic               dp_sof_q;
    logic               err_q;

    logic               w_at_max;
    logic               w_underflow;
    logic [INF_W-1:0]   w_inflight;
    logic               w_admit;
    logic               w_ret;
    logic               w_col_end;
    logic               w_row_end;
    logic               w_last;
    logic               w_first;

    // A return landing in the same cycle does not free a credit for this cycle.
    assign o_src_ready = (state_q == RUN) && !w_at_max;
    assign w_admit     = o_src_ready && i_src_valid;
    assign w_ret       = i_dp_valid_out && !i_sink_busy;
    assign w_col_end   = (col_q == COL_W'(P_COLS - 1));
    assign w_row_end   = (row_q == ROW_W'(P_ROWS - 1));
    assign w_last      = w_admit && w_col_end && w_row_end;
    assign w_first     = (col_q == '0) && (row_q == '0);

    credit_counter #(
        .P_MAX (P_CREDITS),
        .CNT_W (INF_W)
    ) u_credit (
        .i_clk       (i_clk),
        .i_rst       (i_rst),
        .i_inc       (w_admit),
        .i_dec       (w_ret),
        .o_count     (w_inflight),
        .o_at_max    (w_at_max),
        .o_underflow (w_underflow)
    );

    // Frame-level sequencing: start only from IDLE, drain until empty.
    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    if (i_start)            state_d = RUN;
            RUN:     if (w_last)             state_d = DRAIN;
            DRAIN:   if (w_inflight == '0)   state_d = DONE;
            DONE:                            state_d = IDLE;
            default:                         state_d = IDLE;
        endcase
    end

    // Raster position of the next pixel to be admitted.
    always_comb begin
        col_d = col_q;
        row_d = row_q;
        if (w_admit) begin
            if (w_col_end) begin
                col_d = '0;
                row_d = w_row_end ? '0 : row_q + ROW_W'(1);
            end else begin
                col_d = col_q + COL_W'(1);
            end
        end
    end

    // State, counters, datapath output stage and sticky error.
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            state_q    <= IDLE;
            col_q      <= '0;
            row_q      <= '0;
            dp_data_q  <= '0;
            dp_valid_q <= 1'b0;
            dp_sof_q   <= 1'b0;
            err_q      <= 1'b0;
        end else begin
            state_q    <= state_d;
            col_q      <= col_d;
            row_q      <= row_d;
            dp_valid_q <= w_admit;
            dp_sof_q   <= w_admit && w_first;
            if (w_admit) begin
                dp_data_q <= i_src_data;
            end
            if (w_underflow) begin
                err_q <= 1'b1;
            end
        end
    end

    assign o_dp_data    = dp_data_q;
    assign o_dp_valid   = dp_valid_q;
    assign o_dp_sof     = dp_sof_q;
    assign o_inflight   = w_inflight;
    assign o_frame_done = (state_q == DONE);
    assign o_active     = (state_q == RUN) || (state_q == DRAIN);
    assign o_err        = err_q;

endmodule
`default_nettype wire
